gb_cpu_bus_responder: RTL and testbench
=======================================

# gb_cpu_bus_responder

Target side of the CPU memory bus. Each M-cycle the scheduler's control word drives an address and either a read into a register or a write from one; this block services that access. It decodes the address, serves high RAM (HRAM) and the interrupt-enable register (IE) internally, and forwards IO and external-memory accesses. It also runs the OAM DMA engine and applies CPU bus lockout while a DMA transfer is active.

## Interface
- HRAM_BASE, 16'hFF80, first HRAM address (127 bytes, through 16'hFFFE)
- DMA_LEN, 160, bytes copied per OAM DMA
- clk  in  1  M-cycle clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- cpu_addr  in  16  CPU address bus
- cpu_rd  in  1  CPU read request this M-cycle
- cpu_wr  in  1  CPU write request this M-cycle
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  registered read data
- ext_addr  out  16  external memory address
- ext_rd / ext_wr  out  1  external read / write strobes
- ext_wdata  out  8  external write data
- ext_rdata  in  8  external read data, valid in the same cycle as ext_rd
- io_addr  out  7  IO offset (cpu_addr[6:0])
- io_rd / io_wr  out  1  IO read / write strobes
- io_wdata  out  8  IO write data
- io_rdata  in  8  IO read data, valid in the same cycle as io_rd
- oam_addr  out  8  DMA OAM write index
- oam_wr  out  1  DMA OAM write strobe
- oam_wdata  out  8  DMA OAM write data
- ie_o  out  8  current IE register
- dma_active  out  1  DMA owns the external bus

## Operation
- Address regions:
  - FF80–FFFE: HRAM.
  - FFFF: IE.
  - FF46: DMA register.
  - FF00–FF7F except FF46: IO.
  - All other addresses: EXT (this includes OAM at FE00–FE9F).
- Read (cpu_rd=1, cpu_wr=0):
  - The selected source is captured into cpu_rdata at the clock edge.
  - A read of FF46 returns the last value written to it.
- Write (cpu_wr=1): the target is updated at the clock edge. If cpu_rd and cpu_wr are both 1, the write wins and cpu_rdata holds.
- Idle (neither cpu_rd nor cpu_wr): cpu_rdata holds; all forwarding strobes are 0.
- IO and EXT strobes are combinational from the cpu_* inputs and asserted only for the matching region.
- DMA lockout (dma_active=1):
  - EXT reads return 8'hFF and do not assert ext_rd.
  - EXT writes are dropped.
  - HRAM, IE, IO and FF46 accesses proceed normally.
- DMA FSM has three states:
  - IDLE: moves to START on any FF46 write.
  - START: one cycle with dma_active=0; the index is loaded to 0 and the source page is latched. The next state is XFER.
  - XFER: each cycle drives ext_addr={src,idx}, ext_rd=1, oam_addr=idx, oam_wr=1 and oam_wdata=ext_rdata, then increments idx. After idx=DMA_LEN-1 the FSM returns to IDLE.
- Source page: if the written value is ≥ 8'hE0, bit 5 is cleared (echo folding); otherwise it is used as written.
- FF46 write during START or XFER (restart):
  - The current cycle completes as normal.
  - The FSM then enters START, and the next cycle continues the old sequence at its current index.
  - The new transfer then begins at idx 0.
  - dma_active stays 1 through the restart.

## Timing
- Read latency is 1: a request in cycle N gives cpu_rdata valid from N+1 and held until the next read.
- DMA sequence for an FF46 write in cycle N:
  - N+1 is START.
  - N+2 to N+161 are XFER, copying indices 0–159.
  - dma_active=1 in exactly N+2..N+161.
- Reset (reset=0 at a clock edge):
  - cpu_rdata=8'hFF and IE=8'h00; the FF46 register=8'hFF.
  - DMA FSM=IDLE with dma_active=0, oam_wr=0 and idx=0.
  - HRAM contents are not reset.
  - All strobes are 0 while reset=0.
  - A reset mid-DMA aborts the transfer immediately.
- The DMA index is 8 bits and compares against DMA_LEN-1 = 159; no wrap occurs.

## Structure
- Additions to gb_cpu_common_pkg:
  - bus_region_t enum {REGION_HRAM, REGION_IE, REGION_DMA, REGION_IO, REGION_EXT}.
  - dma_state_t enum {DMA_IDLE, DMA_START, DMA_XFER}.
  - Address constants: ADDR_IE=16'hFFFF, ADDR_DMA=16'hFF46, ADDR_IO_BASE=16'hFF00.
- Sub-module gb_cpu_oam_dma contains:
  - the DMA FSM, index counter, source latch and restart logic;
  - outputs for the ext DMA address/strobe, OAM port and dma_active.
- The top level holds the decoder, the HRAM array, IE, the read mux and the lockout logic.

## Test plan
- Reset, then idle: cpu_rdata=FF, ie_o=00, dma_active=0 and all strobes 0.
- Write 5A to FF80, then read FF80: cpu_rdata=5A one cycle after the read. Write 1F to FFFF: ie_o=1F.
- Write 80 to FF46 in cycle N:
  - OAM writes cover idx 0..159 with ext_addr 8000..809F in N+2..N+161;
  - dma_active is high for exactly 160 cycles;
  - a read of FF46 returns 80.
- During DMA:
  - a CPU read of C000 returns FF with ext_rd sourced only by DMA;
  - a CPU write to C000 is dropped;
  - a read of HRAM FF85 returns the stored value.
- Write E3 to FF46: the source page is C3 (ext_addr C300..C39F).
- Restarts:
  - Rewrite 90 to FF46 at idx 50: old idx 50 and 51 complete, then idx 0 restarts at ext_addr 9000 and dma_active never drops.
  - Apply reset at idx 10: dma_active=0 and oam_wr=0 from the next cycle.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the CPU bus responder and its OAM DMA engine.
package gb_cpu_common_pkg;

  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] ADDR_IE      = 16'hFFFF;
  localparam logic [15:0] ADDR_DMA     = 16'hFF46;
  localparam logic [15:0] ADDR_IO_BASE = 16'hFF00;

  localparam int          DMA_LEN  = 160;
  localparam logic [7:0]  DMA_LAST = 8'(DMA_LEN - 1);

  typedef enum logic [2:0] {
    REGION_HRAM,
    REGION_IE,
    REGION_DMA,
    REGION_IO,
    REGION_EXT
  } bus_region_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  // IE sits above the HRAM window, so it is tested first.
  function automatic bus_region_t decode_region(input logic [15:0] addr);
    bus_region_t r;
    if (addr == ADDR_IE)                         r = REGION_IE;
    else if (addr >= HRAM_BASE)                  r = REGION_HRAM;
    else if (addr == ADDR_DMA)                   r = REGION_DMA;
    else if (addr[15:7] == ADDR_IO_BASE[15:7])   r = REGION_IO;
    else                                         r = REGION_EXT;
    return r;
  endfunction

  // Pages E0..FF are echo RAM; map them back onto C0..DF.
  function automatic logic [7:0] fold_page(input logic [7:0] v);
    return (v >= 8'hE0) ? (v & 8'hDF) : v;
  endfunction

endpackage

// File: rtl/gb_cpu_oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {page,idx} into OAM[idx].
//
// state     | meaning
// ----------+------------------------------------------------------------
// DMA_IDLE  | no transfer; waits for a DMA register write
// DMA_START | loads idx=0 and latches the source page; if entered through
//           | a restart (cont=1) it also moves the old transfer's next byte
// DMA_XFER  | one byte per cycle, idx 0..DMA_LAST, then back to idle
module gb_cpu_oam_dma
  import gb_cpu_common_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  page,
  input  logic [7:0]  ext_rdata,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic [7:0]  oam_addr,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  dma_state_t state, state_next;
  logic [7:0] idx, idx_next;
  logic [7:0] src, src_next;
  logic       cont, cont_next;
  logic       xfer;

  // State register with synchronous active-low reset; reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= DMA_IDLE;
      idx   <= '0;
      src   <= '0;
      cont  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      src   <= src_next;
      cont  <= cont_next;
    end
  end

  // Next-state logic; a restart finishes the current byte and keeps the old
  // sequence going for one more START cycle unless it just moved its last byte.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    src_next   = src;
    cont_next  = cont;
    xfer       = (state == DMA_XFER) || ((state == DMA_START) && cont);
    unique case (state)
      DMA_IDLE: begin
        if (start) begin
          state_next = DMA_START;
          idx_next   = '0;
          cont_next  = 1'b0;
        end
      end
      DMA_START, DMA_XFER: begin
        if (start) begin
          state_next = DMA_START;
          cont_next  = xfer && (idx != DMA_LAST);
          idx_next   = cont_next ? idx + 8'd1 : 8'd0;
        end else if (state == DMA_START) begin
          state_next = DMA_XFER;
          idx_next   = '0;
          cont_next  = 1'b0;
          src_next   = fold_page(page);
        end else if (idx == DMA_LAST) begin
          state_next = DMA_IDLE;
          idx_next   = '0;
        end else begin
          idx_next   = idx + 8'd1;
        end
      end
      default: begin
        state_next = DMA_IDLE;
        idx_next   = '0;
        cont_next  = 1'b0;
      end
    endcase
  end

  assign dma_active = reset & xfer;
  assign dma_rd     = reset & xfer;
  assign oam_wr     = reset & xfer;
  assign dma_addr   = {src, idx};
  assign oam_addr   = idx;
  assign oam_wdata  = ext_rdata;

endmodule

// File: rtl/gb_cpu_bus_responder.sv
// CPU bus target: decodes the address, serves HRAM and IE locally, forwards
// IO/EXT accesses and locks the CPU off the external bus during OAM DMA.
module gb_cpu_bus_responder
  import gb_cpu_common_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ext_addr,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  output logic [6:0]  io_addr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  output logic [7:0]  ie_o,
  output logic        dma_active
);

  bus_region_t region;
  logic        rd_only;
  logic [6:0]  hram_idx;
  logic [7:0]  hram [0:126];
  logic [7:0]  ie_reg;
  logic [7:0]  dma_reg;
  logic [7:0]  rd_mux;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        dma_start;

  assign region    = decode_region(cpu_addr);
  assign rd_only   = cpu_rd & ~cpu_wr;
  assign hram_idx  = cpu_addr[6:0];
  assign dma_start = cpu_wr & (region == REGION_DMA);

  gb_cpu_oam_dma u_dma (
    .clk        (clk),
    .reset      (reset),
    .start      (dma_start),
    .page       (dma_reg),
    .ext_rdata  (ext_rdata),
    .dma_addr   (dma_addr),
    .dma_rd     (dma_rd),
    .oam_addr   (oam_addr),
    .oam_wr     (oam_wr),
    .oam_wdata  (oam_wdata),
    .dma_active (dma_active)
  );

  // Forwarding strobes; CPU EXT traffic is suppressed while DMA owns the bus.
  always_comb begin
    io_rd    = reset & (region == REGION_IO) & rd_only;
    io_wr    = reset & (region == REGION_IO) & cpu_wr;
    ext_rd   = dma_rd | (reset & (region == REGION_EXT) & rd_only & ~dma_active);
    ext_wr   = reset & (region == REGION_EXT) & cpu_wr & ~dma_active;
    ext_addr = dma_rd ? dma_addr : cpu_addr;
  end

  assign io_addr   = cpu_addr[6:0];
  assign io_wdata  = cpu_wdata;
  assign ext_wdata = cpu_wdata;
  assign ie_o      = ie_reg;

  // Read source select; locked-out EXT reads float high.
  always_comb begin
    rd_mux = 8'hFF;
    unique case (region)
      REGION_HRAM: rd_mux = hram[hram_idx];
      REGION_IE:   rd_mux = ie_reg;
      REGION_DMA:  rd_mux = dma_reg;
      REGION_IO:   rd_mux = io_rdata;
      REGION_EXT:  rd_mux = dma_active ? 8'hFF : ext_rdata;
      default:     rd_mux = 8'hFF;
    endcase
  end

  // HRAM array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (reset && cpu_wr && (region == REGION_HRAM))
      hram[hram_idx] <= cpu_wdata;
  end

  // IE, DMA register and registered read data; a write takes priority over a read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rdata <= 8'hFF;
      ie_reg    <= 8'h00;
      dma_reg   <= 8'hFF;
    end else if (cpu_wr) begin
      if (region == REGION_IE)  ie_reg  <= cpu_wdata;
      if (region == REGION_DMA) dma_reg <= cpu_wdata;
    end else if (cpu_rd) begin
      cpu_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gb_cpu_bus_responder.sv
// Bench for gb_cpu_bus_responder: a per-cycle DMA plan queue plus register
// model predicts every output; directed stimulus adds literal spot checks.
module tb_gb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [15:0] ext_addr;
  logic        ext_rd, ext_wr;
  logic [7:0]  ext_wdata, ext_rdata;
  logic [6:0]  io_addr;
  logic        io_rd, io_wr;
  logic [7:0]  io_wdata, io_rdata;
  logic [7:0]  oam_addr;
  logic        oam_wr;
  logic [7:0]  oam_wdata;
  logic [7:0]  ie_o;
  logic        dma_active;

  always #5 clk = ~clk;

  gb_cpu_bus_responder dut (
    .clk(clk), .reset(rst_n),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ext_addr(ext_addr), .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata),
    .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .oam_addr(oam_addr), .oam_wr(oam_wr), .oam_wdata(oam_wdata),
    .ie_o(ie_o), .dma_active(dma_active)
  );

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] io_f(input logic [6:0] a);
    return {1'b0, a} ^ 8'hA5;
  endfunction

  assign ext_rdata = mem_f(ext_addr);
  assign io_rdata  = io_f(io_addr);

  // 0 HRAM, 1 IE, 2 DMA reg, 3 IO, 4 EXT
  function automatic int region_of(input logic [15:0] a);
    if (a == 16'hFFFF) return 1;
    if (a >= 16'hFF80) return 0;
    if (a == 16'hFF46) return 2;
    if (a >= 16'hFF00) return 3;
    return 4;
  endfunction

  typedef struct packed {
    logic        v;
    logic [15:0] a;
  } xfer_t;

  xfer_t       plan[$];
  logic [7:0]  hram_m [0:126];
  logic [7:0]  ie_m = 8'h00, ff46_m = 8'hFF, rdata_m = 8'hFF;
  int          vectors = 0, errors = 0;
  bit          run = 1'b0;
  logic [15:0] oam_log[$];
  int          act_cnt = 0, cur_run = 0, max_run = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < oam_log.size()) return oam_log[i];
    return 16'hDEAD;
  endfunction

  // Compare outputs against the model, then advance the model to the next edge.
  always @(negedge clk) begin : mon
    xfer_t cur, first;
    int    rg;
    bit    rdo, x;
    logic [7:0] pg;
    if (run) begin
      cur = (plan.size() > 0) ? plan[0] : xfer_t'(0);
      x   = rst_n && cur.v;
      rg  = region_of(cpu_addr);
      rdo = cpu_rd && !cpu_wr;
      chk("dma_active", dma_active, x);
      chk("oam_wr", oam_wr, x);
      chk("ext_rd", ext_rd, rst_n && (cur.v || (rg == 4 && rdo)));
      chk("ext_wr", ext_wr, rst_n && rg == 4 && cpu_wr && !x);
      chk("io_rd", io_rd, rst_n && rg == 3 && rdo);
      chk("io_wr", io_wr, rst_n && rg == 3 && cpu_wr);
      if (x) begin
        chk("dma_ext_addr", ext_addr, cur.a);
        chk("oam_addr", oam_addr, cur.a[7:0]);
        chk("oam_wdata", oam_wdata, mem_f(cur.a));
      end else if (rst_n && rg == 4 && (rdo || cpu_wr)) begin
        chk("cpu_ext_addr", ext_addr, cpu_addr);
        if (cpu_wr) chk("ext_wdata", ext_wdata, cpu_wdata);
      end
      if (rst_n && rg == 3 && (rdo || cpu_wr)) begin
        chk("io_addr", io_addr, cpu_addr[6:0]);
        if (cpu_wr) chk("io_wdata", io_wdata, cpu_wdata);
      end
      chk("cpu_rdata", cpu_rdata, rdata_m);
      chk("ie_o", ie_o, ie_m);

      if (oam_wr) oam_log.push_back(ext_addr);
      if (dma_active) begin
        act_cnt++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end

      if (!rst_n) begin
        rdata_m = 8'hFF;
        ie_m    = 8'h00;
        ff46_m  = 8'hFF;
        plan.delete();
      end else begin
        if (plan.size() > 0) void'(plan.pop_front());
        if (cpu_wr) begin
          case (rg)
            0: hram_m[cpu_addr[6:0]] = cpu_wdata;
            1: ie_m = cpu_wdata;
            2: begin
              ff46_m = cpu_wdata;
              first  = (plan.size() > 0) ? plan[0] : xfer_t'(0);
              plan.delete();
              plan.push_back(first);
              pg = (cpu_wdata >= 8'hE0) ? (cpu_wdata & 8'hDF) : cpu_wdata;
              for (int i = 0; i < 160; i++) plan.push_back({1'b1, pg, 8'(i)});
            end
            default: ;
          endcase
        end else if (cpu_rd) begin
          case (rg)
            0: rdata_m = hram_m[cpu_addr[6:0]];
            1: rdata_m = ie_m;
            2: rdata_m = ff46_m;
            3: rdata_m = io_f(cpu_addr[6:0]);
            default: rdata_m = x ? 8'hFF : mem_f(cpu_addr);
          endcase
        end
      end
    end
  end

  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [7:0] d);
    rst_n = r; cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic clear_stats();
    oam_log.delete();
    act_cnt = 0;
    cur_run = 0;
    max_run = 0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge clk);
    #1;
    run = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    idle(2);
    chk("rst_rdata", cpu_rdata, 8'hFF);
    chk("rst_ie", ie_o, 8'h00);
    chk("rst_dma_active", dma_active, 1'b0);

    drive(1'b1, 1'b0, 1'b1, 16'hFF80, 8'h5A);
    drive(1'b1, 1'b1, 1'b0, 16'hFF80, 8'h00);
    chk("hram_read", cpu_rdata, 8'h5A);
    drive(1'b1, 1'b0, 1'b1, 16'hFFFF, 8'h1F);
    chk("ie_write", ie_o, 8'h1F);
    drive(1'b1, 1'b0, 1'b1, 16'hFF85, 8'h3C);
    drive(1'b1, 1'b1, 1'b0, 16'hFF01, 8'h00);
    chk("io_read", cpu_rdata, 8'hA4);
    drive(1'b1, 1'b0, 1'b1, 16'hFF10, 8'h22);
    drive(1'b1, 1'b1, 1'b0, 16'h1234, 8'h00);
    chk("ext_read", cpu_rdata, 8'h1A);
    drive(1'b1, 1'b1, 1'b1, 16'h2000, 8'h44);
    chk("rd_wr_hold", cpu_rdata, 8'h1A);
    idle(1);

    // Plain DMA from page 80 with CPU traffic mixed in.
    clear_stats();
    drive(1'b1, 1'b0, 1'b1, 16'hFF46, 8'h80);
    idle(1);
    for (int k = 0; k < 170; k++) begin
      case (k)
        5: begin
          drive(1'b1, 1'b1, 1'b0, 16'hC000, 8'h00);
          chk("locked_ext_read", cpu_rdata, 8'hFF);
        end
        6: drive(1'b1, 1'b0, 1'b1, 16'hC000, 8'h77);
        7: begin
          drive(1'b1, 1'b1, 1'b0, 16'hFF85, 8'h00);
          chk("hram_during_dma", cpu_rdata, 8'h3C);
        end
        8: begin
          drive(1'b1, 1'b1, 1'b0, 16'hFF46, 8'h00);
          chk("ff46_read", cpu_rdata, 8'h80);
        end
        default: idle(1);
      endcase
    end
    chk("dma80_count", oam_log.size(), 16'd160);
    chk("dma80_first", log_at(0), 16'h8000);
    chk("dma80_last", log_at(159), 16'h809F);
    chk("dma80_active_cycles", act_cnt, 16'd160);
    drive(1'b1, 1'b1, 1'b0, 16'hC000, 8'h00);
    chk("ext_read_after_dma", cpu_rdata, 8'hFC);

    // Echo page folds E3 -> C3.
    clear_stats();
    drive(1'b1, 1'b0, 1'b1, 16'hFF46, 8'hE3);
    idle(170);
    chk("echo_first", log_at(0), 16'hC300);
    chk("echo_last", log_at(159), 16'hC39F);
    chk("echo_count", oam_log.size(), 16'd160);

    // Restart at idx 50.
    clear_stats();
    drive(1'b1, 1'b0, 1'b1, 16'hFF46, 8'h80);
    idle(51);
    drive(1'b1, 1'b0, 1'b1, 16'hFF46, 8'h90);
    idle(220);
    chk("restart_count", oam_log.size(), 16'd212);
    chk("restart_old50", log_at(50), 16'h8032);
    chk("restart_old51", log_at(51), 16'h8033);
    chk("restart_new0", log_at(52), 16'h9000);
    chk("restart_new159", log_at(211), 16'h909F);
    chk("restart_run", max_run, 16'd212);

    // Reset at idx 10 aborts the transfer.
    clear_stats();
    drive(1'b1, 1'b0, 1'b1, 16'hFF46, 8'h80);
    idle(11);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("abort_dma_active", dma_active, 1'b0);
    chk("abort_oam_wr", oam_wr, 1'b0);
    idle(5);
    chk("abort_count", oam_log.size(), 16'd10);
    chk("abort_rdata", cpu_rdata, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
